pulse_meas: RTL and testbench

- Receive-side counterpart of the board's square-wave pulse generator.
- Synchronises an external pulse train into the local clock domain and measures each period and high time in clock cycles.
- Checks the period against a nominal value and reports lock and loss of signal.
- Sits at the input pins of the receiving core; its outputs feed status registers and switch-over logic.

---
 rtl/pulse_meas.sv | 116 +++++++++++
 tb/tb_pulse_meas.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_meas.sv
// Pulse-train receiver: synchronises pulse_in, measures rise-to-rise period and
// rise-to-fall high time in clk cycles, and tracks lock and loss of signal.
module pulse_meas #(
   parameter int CNT_W    = 16,
   parameter int NOMINAL  = 14747,
   parameter int TOL      = 64,
   parameter int LOCK_CNT = 4,
   parameter int TIMEOUT  = 30000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pulse_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             locked,
   output logic             lost,
   output logic             no_sig
);

   localparam int                GOOD_W    = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]  PER_MIN   = CNT_W'(NOMINAL - TOL);
   localparam logic [CNT_W-1:0]  PER_MAX   = CNT_W'(NOMINAL + TOL);
   localparam logic [GOOD_W-1:0] GOOD_FULL = GOOD_W'(LOCK_CNT);

   typedef enum logic {S_WAIT, S_RUN} state_t;

   state_t             state, state_nxt;
   logic [2:0]         sync;
   logic               rise, fall;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   high_pend;
   logic [GOOD_W-1:0]  good_cnt;
   logic               good;
   logic               meas_fire, lost_fire, pend_load;

   // sync[1:0] is the synchroniser pair, sync[2] holds the previous synchronised level.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) sync <= '0;
      else     sync <= {sync[1:0], pulse_in};
   end

   assign rise = sync[1] & ~sync[2];
   assign fall = ~sync[1] & sync[2];

   always_ff @(posedge clk) begin
      if (rst)                 cnt <= '0;
      else if (rise)           cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_WAIT;
      else     state <= state_nxt;
   end

   // A rise landing on the timeout cycle counts as a measurement, not a loss.
   // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         S_WAIT:  if (rise) state_nxt = S_RUN;
         S_RUN:   if (!rise && cnt == TIMEOUT_C) state_nxt = S_WAIT;
         default: state_nxt = S_WAIT;
      endcase
   end

   always_comb begin
      meas_fire = 1'b0;
      lost_fire = 1'b0;
      pend_load = 1'b0;
      if (state == S_RUN) begin
         meas_fire = rise;
         lost_fire = !rise && (cnt == TIMEOUT_C);
         pend_load = fall;
      end
   end

   assign good = (cnt >= PER_MIN) && (cnt <= PER_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         period     <= '0;
         high_time  <= '0;
         high_pend  <= '0;
         good_cnt   <= '0;
         meas_valid <= 1'b0;
         locked     <= 1'b0;
         lost       <= 1'b0;
         no_sig     <= 1'b1;
      end else begin
         meas_valid <= meas_fire;
         lost       <= lost_fire;
         no_sig     <= (state_nxt == S_WAIT);
         if (pend_load) high_pend <= cnt;
         if (meas_fire) begin
            period    <= cnt;
            high_time <= high_pend;
            if (good) begin
               if (good_cnt != GOOD_FULL) good_cnt <= good_cnt + GOOD_W'(1);
               if (good_cnt >= GOOD_FULL - GOOD_W'(1)) locked <= 1'b1;
            end else begin
               good_cnt <= '0;
               locked   <= 1'b0;
            end
         end else if (lost_fire) begin
            good_cnt <= '0;
            locked   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pulse_meas.sv
// Self-checking bench for pulse_meas: a timeline model built from the driven edge
// times predicts every output on every cycle (scaled-down parameters keep runs short).
module tb_pulse_meas;

   localparam int CNT_W    = 10;
   localparam int NOMINAL  = 200;
   localparam int TOL      = 6;
   localparam int LOCK_CNT = 4;
   localparam int TIMEOUT  = 400;
   localparam int LAT      = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             pulse_in;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             meas_valid;
   logic             locked;
   logic             lost;
   logic             no_sig;

   pulse_meas #(
      .CNT_W(CNT_W), .NOMINAL(NOMINAL), .TOL(TOL),
      .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .pulse_in(pulse_in),
      .period(period), .high_time(high_time), .meas_valid(meas_valid),
      .locked(locked), .lost(lost), .no_sig(no_sig)
   );

   always #5 clk = ~clk;

   int tick = 0;
   always @(posedge clk) tick++;

   typedef struct {
      int t;
      bit up;
   } pin_evt_t;

   pin_evt_t evts[$];

   int checks   = 0;
   int failures = 0;
   bit checking = 1'b0;

   // Reference model state, expressed as times of driven pin edges.
   bit m_run;
   int m_last_rise, m_pend, m_period, m_high, m_good;
   bit m_locked, m_mv, m_lost;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s tick=%0d got=%0d expected=%0d", tag, tick, got, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_last_rise = 0; m_pend = 0; m_period = 0; m_high = 0;
      m_good = 0; m_locked = 0; m_mv = 0; m_lost = 0;
   endtask

   task automatic model_step(input int k);
      pin_evt_t e;
      bit rose;
      rose   = 0;
      m_mv   = 0;
      m_lost = 0;
      if (evts.size() > 0 && evts[0].t + LAT == k) begin
         e = evts.pop_front();
         if (e.up) begin
            rose = 1;
            if (m_run) begin
               m_period = e.t - m_last_rise;
               m_high   = m_pend;
               m_mv     = 1;
               if (m_period >= NOMINAL - TOL && m_period <= NOMINAL + TOL) begin
                  if (m_good < LOCK_CNT) m_good++;
               end else begin
                  m_good = 0;
               end
               m_locked = (m_good == LOCK_CNT);
            end
            m_run       = 1;
            m_last_rise = e.t;
         end else if (m_run) begin
            m_pend = e.t - m_last_rise;
         end
      end
      if (!rose && m_run && (k - LAT - m_last_rise) == TIMEOUT) begin
         m_run    = 0;
         m_good   = 0;
         m_locked = 0;
         m_lost   = 1;
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         model_step(tick);
         check("meas_valid", 32'(meas_valid), 32'(m_mv));
         check("lost",       32'(lost),       32'(m_lost));
         check("locked",     32'(locked),     32'(m_locked));
         check("no_sig",     32'(no_sig),     32'(!m_run));
         check("period",     32'(period),     32'(m_period));
         check("high_time",  32'(high_time),  32'(m_high));
      end
      if (rst) begin
         model_reset();
         evts.delete();
         checking = 1'b1;
      end
   end

   task automatic drive(input bit v, input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (v != pulse_in) evts.push_back('{t: tick, up: v});
         pulse_in = v;
      end
   endtask

   task automatic sq(input int hi, input int lo);
      drive(1'b1, hi);
      drive(1'b0, lo);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog tick=%0d got=timeout expected=finish", tick);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p, h;
      rst      = 1'b1;
      pulse_in = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Long idle: stays in WAIT while the counter saturates.
      drive(1'b0, 1500);

      // Nominal square wave until locked.
      repeat (7) sq(100, 100);

      // Tolerance boundaries: +TOL+1 bad, +TOL good, -TOL-1 bad, -TOL good.
      sq(100, 107);
      repeat (5) sq(100, 106);
      sq(100, 93);
      repeat (5) sq(97, 97);

      // Input stuck high: loss, then reacquire.
      drive(1'b1, 600);
      drive(1'b0, 50);
      repeat (7) sq(100, 100);

      // Reset in the middle of a low phase while locked.
      drive(1'b1, 100);
      drive(1'b0, 50);
      pulse_reset();
      drive(1'b0, 50);
      repeat (6) sq(100, 100);

      // Rise exactly at the timeout count, then one cycle past it.
      sq(100, TIMEOUT - 100);
      sq(100, 100);
      sq(100, TIMEOUT - 99);
      repeat (3) sq(100, 100);

      // Random periods around nominal, with occasional near-timeout gaps.
      repeat (60) begin
         if ($urandom_range(0, 9) == 0) p = $urandom_range(TIMEOUT - 1, TIMEOUT + 1);
         else                           p = $urandom_range(NOMINAL - 2 * TOL, NOMINAL + 2 * TOL);
         h = $urandom_range(1, p - 1);
         sq(h, p - h);
      end
      drive(1'b0, 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
